// File: rtl/axis_decimator_v1_0_pkg.sv
// rtl/axis_decimator_v1_0_pkg.sv - shared widths and ratio rule for the FIR/decimator chain
package axis_decimator_v1_0_pkg;

    // Sample width is common with the FIR stage output width.
    localparam int unsigned default_data_width  = 16;
    localparam int unsigned default_ratio_width = 8;

    // A ratio of zero behaves exactly like a ratio of one (passthrough).
    function automatic int unsigned effective_ratio(input int unsigned ratio);
        return (ratio == 32'd0) ? 32'd1 : ratio;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - two-entry stream skid buffer with registered upstream ready
module axis_skid_buffer #(
    parameter int unsigned width = 17
) (
    input  logic             aclk,
    input  logic             resetn,
    input  logic [width-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [width-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    logic [width-1:0] main_data, main_data_n;
    logic [width-1:0] skid_data, skid_data_n;
    logic             main_valid, main_valid_n;
    logic             skid_valid, skid_valid_n;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = s_axis_tvalid && ready_q;
    assign pop  = main_valid && m_axis_tready;

    // Next-state: main register always holds the oldest entry; skid only fills behind a stalled main.
    always_comb begin
        main_data_n  = main_data;
        main_valid_n = main_valid;
        skid_data_n  = skid_data;
        skid_valid_n = skid_valid;
        if (skid_valid) begin
            if (pop) begin
                main_data_n = skid_data;
                if (push) begin
                    skid_data_n = s_axis_tdata;
                end else begin
                    skid_valid_n = 1'b0;
                end
            end
        end else if (push) begin
            if (!main_valid || pop) begin
                main_data_n  = s_axis_tdata;
                main_valid_n = 1'b1;
            end else begin
                skid_data_n  = s_axis_tdata;
                skid_valid_n = 1'b1;
            end
        end else if (pop) begin
            main_valid_n = 1'b0;
        end
    end

    // State registers; ready is registered so it never depends combinationally on m_axis_tready.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            main_data  <= '0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            main_data  <= main_data_n;
            main_valid <= main_valid_n;
            skid_data  <= skid_data_n;
            skid_valid <= skid_valid_n;
            ready_q    <= !skid_valid_n;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tdata  = main_data;
    assign m_axis_tvalid = main_valid;

endmodule

// File: rtl/axis_decimator_v1_0.sv
// rtl/axis_decimator_v1_0.sv - frame-aligned stream decimator behind the FIR stage
module axis_decimator_v1_0
    import axis_decimator_v1_0_pkg::*;
#(
    parameter int unsigned data_width  = default_data_width,
    parameter int unsigned ratio_width = default_ratio_width
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic [data_width-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [data_width-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic [ratio_width-1:0] ratio
);

    logic [ratio_width-1:0] phase;
    logic [ratio_width-1:0] ratio_l;
    logic [ratio_width-1:0] cur_ratio;
    logic                   accept;
    logic                   keep;

    // The group's ratio is taken live at phase 0 and frozen for the rest of the group.
    assign cur_ratio = (phase == '0) ? ratio_width'(effective_ratio(32'(ratio))) : ratio_l;
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign keep      = accept && (s_axis_tlast || (phase == cur_ratio - ratio_width'(1)));

    // Phase counter and ratio latch; tlast closes the group early so groups align to frames.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            phase   <= '0;
            ratio_l <= ratio_width'(1);
        end else if (accept) begin
            if (phase == '0) begin
                ratio_l <= cur_ratio;
            end
            phase <= keep ? '0 : phase + ratio_width'(1);
        end
    end

    // Dropped samples never reach the buffer, so they are accepted whenever ready is high.
    axis_skid_buffer #(
        .width(data_width + 1)
    ) u_skid (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axis_tdata  ({s_axis_tlast, s_axis_tdata}),
        .s_axis_tvalid (keep),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  ({m_axis_tlast, m_axis_tdata}),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_axis_decimator_v1_0.sv
// tb/tb_axis_decimator_v1_0.sv - directed self-checking bench for axis_decimator_v1_0
module tb_axis_decimator_v1_0;

    logic        aclk;
    logic        resetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [7:0]  ratio;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] out_q[$];
    logic [16:0] in_q[$];

    axis_decimator_v1_0 dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .ratio         (ratio)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Record handshakes that will complete on the coming edge, then advance one cycle.
    task automatic step;
        if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
        if (s_axis_tvalid && s_axis_tready) in_q.push_back({s_axis_tlast, s_axis_tdata});
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        logic acc;
        int   tries;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            acc = s_axis_tready;
            step();
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: sample %0d not accepted, required accept within 50 cycles", d);
        end
    endtask

    task automatic drain;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (6) step();
    endtask

    task automatic test_reset;
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        ratio         = 8'd1;
        repeat (3) step();
        n_cmp++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b data=%0d, required all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (s_axis_tready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_before_edge: got %b, required 0", s_axis_tready);
        end
        step();
        n_cmp++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b vld=%b, required rdy=1 vld=0", s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_ratio4;
        out_q.delete();
        ratio = 8'd4;
        m_axis_tready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            send(16'(k), 1'b0);
            n_cmp++;
            if ((k % 4) == 0) begin
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'(k) || m_axis_tlast !== 1'b0) begin
                    n_err++;
                    $display("FAIL ratio4_latency k=%0d: got vld=%b data=%0d, required vld=1 data=%0d",
                             k, m_axis_tvalid, m_axis_tdata, k);
                end
            end else if (m_axis_tvalid !== 1'b0) begin
                n_err++;
                $display("FAIL ratio4_drop k=%0d: got vld=%b, required 0", k, m_axis_tvalid);
            end
        end
        drain();
        n_cmp++;
        if (out_q.size() != 3 || out_q[0] !== 17'd4 || out_q[1] !== 17'd8 || out_q[2] !== 17'd12) begin
            n_err++;
            $display("FAIL ratio4_sequence: got %p, required 4 8 12", out_q);
        end
    endtask

    task automatic test_tlast_align;
        logic [16:0] exp[3];
        exp[0] = {1'b0, 16'd4};
        exp[1] = {1'b1, 16'd6};
        exp[2] = {1'b0, 16'd10};
        out_q.delete();
        ratio = 8'd4;
        for (int k = 1; k <= 10; k++) send(16'(k), k == 6);
        drain();
        n_cmp++;
        if (out_q.size() != 3) begin
            n_err++;
            $display("FAIL tlast_count: got %0d outputs, required 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (out_q[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL tlast_item%0d: got last=%b data=%0d, required last=%b data=%0d",
                             i, out_q[i][16], out_q[i][15:0], exp[i][16], exp[i][15:0]);
                end
            end
        end
    endtask

    task automatic test_ratio_change;
        for (int r = 0; r < 2; r++) begin
            out_q.delete();
            ratio = 8'(r);
            send(16'd5, 1'b0);
            send(16'd6, 1'b0);
            send(16'd7, 1'b0);
            drain();
            n_cmp++;
            if (out_q.size() != 3 || out_q[0] !== 17'd5 || out_q[1] !== 17'd6 || out_q[2] !== 17'd7) begin
                n_err++;
                $display("FAIL passthrough_ratio%0d: got %p, required 5 6 7", r, out_q);
            end
        end
        out_q.delete();
        ratio = 8'd3;
        send(16'd1, 1'b0);
        ratio = 8'd2;
        for (int k = 2; k <= 5; k++) send(16'(k), 1'b0);
        drain();
        n_cmp++;
        if (out_q.size() != 2 || out_q[0] !== 17'd3 || out_q[1] !== 17'd5) begin
            n_err++;
            $display("FAIL ratio_change: got %p, required 3 5", out_q);
        end
    endtask

    task automatic test_backpressure;
        int nxt;
        out_q.delete();
        ratio = 8'd1;
        m_axis_tready = 1'b0;
        nxt = 1;
        for (int c = 0; c < 5; c++) begin
            logic acc;
            s_axis_tdata  = 16'(nxt);
            s_axis_tlast  = 1'b0;
            s_axis_tvalid = 1'b1;
            acc = s_axis_tready;
            step();
            if (acc) nxt++;
            n_cmp++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd1) begin
                n_err++;
                $display("FAIL stall_hold c=%0d: got vld=%b data=%0d, required vld=1 data=1", c, m_axis_tvalid, m_axis_tdata);
            end
        end
        n_cmp++;
        if (s_axis_tready !== 1'b0 || nxt != 3) begin
            n_err++;
            $display("FAIL stall_ready: got rdy=%b accepted=%0d, required rdy=0 accepted=2", s_axis_tready, nxt - 1);
        end
        m_axis_tready = 1'b1;
        for (int k = 3; k <= 8; k++) send(16'(k), 1'b0);
        drain();
        n_cmp++;
        if (out_q.size() != 8) begin
            n_err++;
            $display("FAIL release_count: got %0d, required 8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (out_q[i] !== 17'(i + 1)) begin
                    n_err++;
                    $display("FAIL release_item%0d: got %0d, required %0d", i, out_q[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_random;
        int          acc_n;
        int          cyc;
        logic        stall;
        logic [16:0] prev;
        out_q.delete();
        in_q.delete();
        ratio = 8'd1;
        acc_n = 0;
        cyc   = 0;
        while (in_q.size() < 1000 && cyc < 20000) begin
            acc_n         = in_q.size();
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = 16'(acc_n * 37 + 5);
            s_axis_tlast  = 1'(acc_n % 3 == 0);
            m_axis_tready = 1'($urandom_range(0, 1));
            stall = m_axis_tvalid && !m_axis_tready;
            prev  = {m_axis_tlast, m_axis_tdata};
            step();
            cyc++;
            if (stall) begin
                n_cmp++;
                if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev) begin
                    n_err++;
                    $display("FAIL rand_stable cyc=%0d: got vld=%b val=%0h, required vld=1 val=%0h",
                             cyc, m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, prev);
                end
            end
        end
        drain();
        n_cmp++;
        if (in_q.size() < 1000 || out_q.size() != in_q.size()) begin
            n_err++;
            $display("FAIL rand_count: got in=%0d out=%0d, required in>=1000 out=in", in_q.size(), out_q.size());
        end else begin
            for (int i = 0; i < in_q.size(); i++) begin
                n_cmp++;
                if (out_q[i] !== in_q[i]) begin
                    n_err++;
                    $display("FAIL rand_item%0d: got %0h, required %0h", i, out_q[i], in_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        ratio = 8'd1;
        m_axis_tready = 1'b0;
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        s_axis_tvalid = 1'b0;
        step();
        n_cmp++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_full: got rdy=%b vld=%b, required rdy=0 vld=1", s_axis_tready, m_axis_tvalid);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'd0 || s_axis_tready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_reset: got vld=%b data=%0d rdy=%b, required 0 0 0",
                     m_axis_tvalid, m_axis_tdata, s_axis_tready);
        end
        step();
        resetn = 1'b1;
        step();
        ratio = 8'd4;
        send(16'd10, 1'b1);
        send(16'd11, 1'b0);
        send(16'd12, 1'b0);
        s_axis_tvalid = 1'b0;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_phase2_reset: got vld=%b, required 0", m_axis_tvalid);
        end
        step();
        resetn = 1'b1;
        step();
        out_q.delete();
        m_axis_tready = 1'b1;
        for (int k = 20; k <= 23; k++) send(16'(k), 1'b0);
        drain();
        n_cmp++;
        if (out_q.size() != 1 || out_q[0] !== 17'd23) begin
            n_err++;
            $display("FAIL mid_phase_cleared: got %p, required 23", out_q);
        end
    endtask

    initial begin
        test_reset();
        test_ratio4();
        test_tlast_align();
        test_ratio_change();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
